// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// ----------------------------------------------------------------------------
// Multi-cycle data-memory access stage. It accepts one load or store request
// from the register-read stage, runs exactly one bus transaction for it, and
// returns a lane-aligned, sign/zero-extended load result for write-back.
// It owns byte-lane steering, write strobes, the valid/ready handshake and
// bus-timeout detection.
//
// Optional build feature:
//   MISALIGN_TRAP_EN  when defined, a misaligned half or word access raises
//                     fault without issuing any bus request.
//
// Parameters:
//   TIMEOUT      max cycles mem_valid may wait for mem_ready (0 = never)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request strobe, only sampled while idle
//   is_store     1 = store, 0 = load
//   size         00 byte, 01 half, 10/11 word
//   is_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   addr         byte address
//   store_data   store operand in the low bits
//   busy         transaction in flight (cycle after accept through done)
//   done         one-cycle completion pulse
//   fault        qualifies done: timeout or misaligned access
//   load_data    extended load result, held until the next successful load
//   mem_valid    bus request
//   mem_we       bus write enable
//   mem_addr     word-aligned bus address
//   mem_wdata    store data replicated across the lanes of its size
//   mem_wstrb    byte enables, zero for loads
//   mem_ready    bus accept/complete, mem_rdata valid in the same cycle
//   mem_rdata    bus read data
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic           fault_q, fault_d;
    logic           timeout_hit;
    logic           misalign;
    logic           accept;

    logic           is_store_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [1:0]     off_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_wdata_q;
    logic [3:0]     mem_wstrb_q;
    logic [31:0]    load_data_q;

    logic [3:0]     wstrb_new;
    logic [31:0]    wdata_new;
    logic [7:0]     lane_byte;
    logic [15:0]    lane_half;
    logic [31:0]    ld_ext;

    assign accept  = (state_q == S_IDLE) && start;
    assign cnt_inc = cnt_q + CW'(1);

    // The timeout fires on the REQ cycle whose increment would make the wait
    // count equal TIMEOUT, so mem_valid is seen for exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT > 0) && (int'(cnt_inc) == TIMEOUT);

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word (size 10 or 11) needs addr[1:0]=0.
    assign misalign = ((size == 2'b01) && addr[0]) ||
                      (size[1] && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // State register, plus the timeout counter and fault flag that travel
    // with the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic. A ready in the same cycle the timeout would fire
    // takes priority, so a late but in-budget response is not a fault.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (misalign) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                    fault_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                fault_d = 1'b0;
            end
        endcase
    end

    // Handshake outputs decode straight from the state register so an
    // asynchronous reset drops mem_valid without waiting for a clock edge.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        fault     = (state_q == S_DONE) && fault_q;
        mem_valid = (state_q == S_REQ);
        mem_we    = (state_q == S_REQ) && is_store_q;
    end

    // Lane steering for the incoming request: strobes select the bytes the
    // store touches and the data is replicated so every lane carries it.
    always_comb begin
        wstrb_new = 4'b0000;
        wdata_new = store_data;
        case (size)
            2'b00: begin
                wstrb_new = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_new = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_new = 4'b1111;
                wdata_new = store_data;
            end
        endcase
        if (!is_store) begin
            wstrb_new = 4'b0000;
        end
    end

    // Load extraction uses the request fields latched at accept, since the
    // register-read inputs may have moved on while the bus is waiting.
    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h000000, lane_byte}
                                    : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   ld_ext = uns_q ? {16'h0000, lane_half}
                                    : {{16{lane_half[15]}}, lane_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Request latches and the load result. The result register is written
    // on the ready edge so it is already valid during the done cycle;
    // stores, timeouts and misalign traps never reach this path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q  <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            load_data_q <= 32'h0;
        end else begin
            if (accept) begin
                is_store_q  <= is_store;
                size_q      <= size;
                uns_q       <= is_unsigned;
                off_q       <= addr[1:0];
                mem_addr_q  <= {addr[31:2], 2'b00};
                mem_wdata_q <= wdata_new;
                mem_wstrb_q <= wstrb_new;
            end
            if ((state_q == S_REQ) && mem_ready && !is_store_q) begin
                load_data_q <= ld_ext;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign load_data = load_data_q;

endmodule
